// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped write-back write-allocate L1 data cache with single-outstanding memory port
module l1_dcache #(
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_req_store,
    input  logic [31:0] cpu_req_addr,
    input  logic [31:0] cpu_req_wdata,
    output logic        cpu_resp_valid,
    output logic [31:0] cpu_resp_rdata,
    output logic        l1_mem_valid,
    output logic        l1_mem_store,
    output logic [31:0] l1_mem_addr,
    output logic [31:0] l1_mem_wdata,
    input  logic [31:0] mem_l1_rdata,
    input  logic        mem_l1_valid
);
    localparam int IB = $clog2(NUM_LINES);
    localparam int CB = $clog2(WORDS_PER_LINE);
    localparam int OB = 2 + CB;
    localparam int TW = 32 - OB - IB;

    typedef enum logic [2:0] {IDLE, COMPARE, WB_ISSUE, WB_WAIT, RF_ISSUE, RF_WAIT, RESP} state_t;

    state_t                state, state_n;
    logic [CB-1:0]         cnt, cnt_n;
    logic                  req_store;
    logic [31:0]           req_addr, req_wdata;
    logic [NUM_LINES-1:0]  valid, dirty;
    logic [TW-1:0]         tags [NUM_LINES];
    logic [31:0]           data [NUM_LINES][WORDS_PER_LINE];
    logic [IB-1:0]         idx;
    logic [TW-1:0]         tag;
    logic [CB-1:0]         off;
    logic                  hit, last, unused_addr_lo;

    assign idx            = req_addr[OB+IB-1:OB];
    assign tag            = req_addr[31:OB+IB];
    assign off            = req_addr[OB-1:2];
    assign unused_addr_lo = ^req_addr[1:0];
    assign hit            = valid[idx] && (tags[idx] == tag);
    assign last           = cnt == CB'(WORDS_PER_LINE - 1);
    assign cpu_req_ready  = rst_n && (state == IDLE);
    assign cpu_resp_valid = state == RESP;
    assign l1_mem_valid   = (state == WB_ISSUE) || (state == RF_ISSUE);

    // next-state and word-counter sequencing
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE:     if (cpu_req_valid) state_n = COMPARE;
            COMPARE:  begin
                if (hit) state_n = RESP;
                else begin
                    cnt_n   = '0;
                    state_n = (valid[idx] && dirty[idx]) ? WB_ISSUE : RF_ISSUE;
                end
            end
            WB_ISSUE: state_n = WB_WAIT;
            WB_WAIT:  if (mem_l1_valid) begin
                cnt_n   = cnt + CB'(1);
                state_n = last ? RF_ISSUE : WB_ISSUE;
            end
            RF_ISSUE: state_n = RF_WAIT;
            RF_WAIT:  if (mem_l1_valid) begin
                cnt_n   = cnt + CB'(1);
                state_n = last ? COMPARE : RF_ISSUE;
            end
            RESP:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // control state, line status bits, request latch and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            valid          <= '0;
            dirty          <= '0;
            req_store      <= 1'b0;
            req_addr       <= '0;
            req_wdata      <= '0;
            cpu_resp_rdata <= '0;
            l1_mem_store   <= 1'b0;
            l1_mem_addr    <= '0;
            l1_mem_wdata   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && cpu_req_valid) begin
                req_store <= cpu_req_store;
                req_addr  <= cpu_req_addr;
                req_wdata <= cpu_req_wdata;
            end
            if (state == COMPARE && hit) begin
                cpu_resp_rdata <= req_store ? req_wdata : data[idx][off];
                if (req_store) dirty[idx] <= 1'b1;
            end
            if (state == WB_WAIT && mem_l1_valid && last) dirty[idx] <= 1'b0;
            if (state == RF_WAIT && mem_l1_valid && last) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
            if (state_n == WB_ISSUE) begin
                l1_mem_store <= 1'b1;
                l1_mem_addr  <= {tags[idx], idx, cnt_n, 2'b00};
                l1_mem_wdata <= data[idx][cnt_n];
            end
            if (state_n == RF_ISSUE) begin
                l1_mem_store <= 1'b0;
                l1_mem_addr  <= {tag, idx, cnt_n, 2'b00};
            end
        end
    end

    // tag and data arrays carry no reset; validity is tracked by the valid bits
    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && req_store) data[idx][off] <= req_wdata;
        if (state == RF_WAIT && mem_l1_valid) begin
            data[idx][cnt] <= mem_l1_rdata;
            if (last) tags[idx] <= tag;
        end
    end
endmodule

// File: doc/l1_dcache.md
# l1_dcache

Direct-mapped, write-back, write-allocate L1 data cache between the CPU load/store port and the word-addressed backing memory. Accepts one CPU request at a time, services hits from internal arrays, and on a miss writes back a dirty victim line and refills the target line through the single-outstanding memory request port (l1_mem_* / mem_l1_*). It is the block directly upstream of the memory model and the only master of that port.

## Interface
- NUM_LINES, 64, number of cache lines; power of two, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, at least 2.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  cache can accept; high only in IDLE.
- cpu_req_store  in  1  0 load, 1 store (full 32-bit word).
- cpu_req_addr  in  32  byte address; bits [1:0] ignored.
- cpu_req_wdata  in  32  store data.
- cpu_resp_valid  out  1  one-cycle pulse, request complete.
- cpu_resp_rdata  out  32  load data; for stores, the stored word.
- l1_mem_valid  out  1  memory request, one-cycle pulse per word.
- l1_mem_store  out  1  0 load, 1 store.
- l1_mem_addr  out  32  word-aligned byte address.
- l1_mem_wdata  out  32  store data.
- mem_l1_rdata  in  32  load data, valid with mem_l1_valid.
- mem_l1_valid  in  1  memory completion for the outstanding request.

## Operation
- Address split: offset [OB-1:2], OB = 2+log2(WORDS_PER_LINE); index [OB+IB-1:OB], IB = log2(NUM_LINES); tag = remaining upper bits.
- Per line: valid bit, dirty bit, tag, WORDS_PER_LINE data words. Valid and dirty cleared on reset; tag/data arrays not reset.
- States: IDLE, COMPARE, WB_ISSUE, WB_WAIT, RF_ISSUE, RF_WAIT, RESP.
- IDLE: cpu_req_ready=1; on cpu_req_valid latch store/addr/wdata, go COMPARE. Requests while not IDLE are ignored (ready low).
- COMPARE: hit = valid && tag match. Hit load: capture word into rdata. Hit store: write word, set dirty, rdata = wdata. Hit → RESP. Miss with valid&&dirty victim → WB_ISSUE, word counter 0. Otherwise → RF_ISSUE, counter 0.
- WB_ISSUE: l1_mem_valid=1, store=1, addr = {victim tag, index, counter, 2'b00}, wdata = victim word[counter]; → WB_WAIT. WB_WAIT: on mem_l1_valid, counter+1; after last word clear dirty, counter 0, → RF_ISSUE; else → WB_ISSUE.
- RF_ISSUE: l1_mem_valid=1, store=0, addr = {req tag, index, counter, 2'b00}; → RF_WAIT. RF_WAIT: on mem_l1_valid write mem_l1_rdata into word[counter], counter+1; after last word write tag, set valid, clear dirty, → COMPARE (now hits); else → RF_ISSUE.
- Word order always ascending from offset 0. Block never relies on fixed memory latency; it waits for mem_l1_valid. mem_l1_valid outside *_WAIT is ignored.
- RESP: cpu_resp_valid=1 with rdata; → IDLE.

## Timing
- All outputs registered or decoded from state; no input-to-output combinational path.
- Reset values: cpu_req_ready=0 during reset, 1 in first cycle after release (IDLE); cpu_resp_valid=0, cpu_resp_rdata=0, l1_mem_valid=0, l1_mem_store=0, l1_mem_addr=0, l1_mem_wdata=0.
- Request accepted at edge ending cycle N: COMPARE in N+1, hit response in N+2.
- Each memory word costs 2 cycles against a 1-cycle memory (ISSUE, WAIT).
- Clean miss, default params: mem requests in N+2,4,6,8; response in N+11.
- Dirty miss: stores N+2..N+8, loads N+10..N+16, response N+19.
- l1_mem_* fields hold their values while l1_mem_valid is low; l1_mem_valid high at most one cycle per word.
- Reset mid-operation: return to IDLE immediately, all lines invalid, partial refill discarded, no response issued.

## Test plan
(Backing memory preloads word i with value i; default params; index = addr[9:4].)
- After reset, load 0x100 -> memory loads 0x100,0x104,0x108,0x10C; resp at N+11, rdata 0x40.
- Load 0x108 after that -> hit, no l1_mem_valid, resp at N+2, rdata 0x42.
- Store 0x104 = 0xDEADBEEF -> hit, no memory traffic, resp N+2; load 0x104 -> 0xDEADBEEF.
- Load 0x500 (same index, dirty victim) -> stores 0x100..0x10C with 0x40,0xDEADBEEF,0x42,0x43, then loads 0x500..0x50C; resp N+19, rdata 0x140; then load 0x104 -> clean miss, rdata 0xDEADBEEF.
- Hold cpu_req_valid high with a new request during a refill -> cpu_req_ready low, not accepted until IDLE, then serviced exactly once.
- Assert rst_n low during RF_WAIT -> all outputs reset values; reload same address -> full miss sequence again, correct data.
